// File: rtl/seq_add_sub_pkg.sv
// Shared encodings for seq_add_sub: FSM states, operation modes and counter sizing.
package seq_add_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // A single-slice configuration still needs a 1-bit counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_add_sub_slice_adder.sv
// Combinational SLICE-bit ripple-carry adder assembled from full_adder cells.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module slice_adder #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             carry_in,
  output logic [SLICE-1:0] sum,
  output logic             carry_out
);
  logic [SLICE:0] w_c;

  assign w_c[0] = carry_in;

  for (genvar i = 0; i < SLICE; i++) begin : g_fa
    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (w_c[i]),
      .s  (sum[i]),
      .co (w_c[i+1])
    );
  end

  assign carry_out = w_c[SLICE];
endmodule

// File: rtl/seq_add_sub.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands processed SLICE bits per clock.
// Optional zero flag is built only when SEQ_ADD_SUB_ZERO_FLAG_EN is defined.
module seq_add_sub
  import seq_add_sub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);
  localparam int N     = WIDTH / SLICE;
  localparam int CNT_W = cnt_width(N);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  state_t                r_state, w_state_next;
  logic [WIDTH-1:0]      r_a, r_b, r_sum;
  logic                  r_carry;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_carry_out, r_overflow;
  logic [SLICE-1:0]      w_slice_sum;
  logic                  w_slice_co;
  logic [WIDTH+SLICE-1:0] w_sum_cat;
  logic [WIDTH-1:0]      w_sum_next;
  logic                  w_accept, w_run, w_last;

  slice_adder #(.SLICE(SLICE)) u_slice (
    .a         (r_a[SLICE-1:0]),
    .b         (r_b[SLICE-1:0]),
    .carry_in  (r_carry),
    .sum       (w_slice_sum),
    .carry_out (w_slice_co)
  );

  // New slice enters at the MSB end; the concatenation stays valid when SLICE == WIDTH.
  assign w_sum_cat  = {w_slice_sum, r_sum};
  assign w_sum_next = w_sum_cat[WIDTH+SLICE-1:SLICE];
  assign w_accept   = in_valid && (r_state == IDLE);
  assign w_run      = (r_state == RUN);
  assign w_last     = w_run && (r_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = RUN;
      end
      RUN:  if (r_cnt == LAST) w_state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Operand shift registers carry no reset; they are always reloaded on accept.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a <= a;
      r_b <= (mode == MODE_SUB) ? ~b : b;
    end else if (w_run) begin
      r_a <= r_a >> SLICE;
      r_b <= r_b >> SLICE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_carry     <= 1'b0;
      r_sum       <= '0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (w_accept) begin
      r_cnt   <= '0;
      r_carry <= (mode == MODE_ADD) ? carry_in : 1'b1;
    end else if (w_run) begin
      r_sum   <= w_sum_next;
      r_carry <= w_slice_co;
      if (w_last) begin
        r_cnt       <= '0;
        r_carry_out <= w_slice_co;
        r_overflow  <= r_a[SLICE-1] ^ r_b[SLICE-1] ^ w_slice_sum[SLICE-1] ^ w_slice_co;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

`ifdef SEQ_ADD_SUB_ZERO_FLAG_EN
  logic r_zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_zero <= 1'b0;
    else if (w_last) r_zero <= (w_sum_next == '0);
  end

  assign zero = r_zero;
`else
  assign zero = 1'b0;
`endif

  assign sum       = r_sum;
  assign carry_out = r_carry_out;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_seq_add_sub.sv
// Directed-vector bench for seq_add_sub (WIDTH=32, SLICE=8).
module tb_seq_add_sub;
  localparam int WIDTH = 32;
  localparam int SLICE = 8;
  localparam int N     = WIDTH / SLICE;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a, b;
  logic             mode;
  logic             carry_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;
  logic             zero;

  seq_add_sub #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .mode      (mode),
    .carry_in  (carry_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mode;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] s;
    logic        co;
    logic        ov;
    logic        z;
  } vec_t;

  vec_t vecs[7];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic zexp(input logic z);
`ifdef SEQ_ADD_SUB_ZERO_FLAG_EN
    return z;
`else
    return 1'b0 & z;
`endif
  endfunction

  // Called #1 after an edge with the DUT idle; returns #1 after the accept edge.
  task automatic start(input logic m, input logic [31:0] aa, input logic [31:0] bb, input logic c);
    in_valid = 1'b1;
    mode     = m;
    a        = aa;
    b        = bb;
    carry_in = c;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!out_valid && n < 20);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int n;
    check({tag, ".in_ready"}, in_ready, 1);
    start(v.mode, v.a, v.b, v.cin);
    wait_result(n);
    check({tag, ".latency"},   n, N);
    check({tag, ".sum"},       sum, v.s);
    check({tag, ".carry_out"}, carry_out, v.co);
    check({tag, ".overflow"},  overflow, v.ov);
    check({tag, ".zero"},      zero, zexp(v.z));
    @(posedge clk); #1;
    check({tag, ".back_idle"}, in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n, e;
    bit  got1, acc;
    logic [31:0] held;

    vecs[0] = '{1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 32'h00000001, 32'h00000002, 1'b1, 32'h00000004, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 32'h12345678, 32'h12345678, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 32'h0000FF00, 32'h00000100, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; mode = 1'b0; carry_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.in_ready",  in_ready, 1);
    check("reset.out_valid", out_valid, 0);
    check("reset.sum",       sum, 0);
    check("reset.carry_out", carry_out, 0);
    check("reset.overflow",  overflow, 0);
    check("reset.zero",      zero, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: result must hold and new operands must be ignored.
    out_ready = 1'b0;
    start(1'b0, 32'h11111111, 32'h22222222, 1'b0);
    wait_result(n);
    check("bp.latency", n, N);
    check("bp.sum", sum, 32'h33333333);
    in_valid = 1'b1; a = 32'hFFFFFFFF; b = 32'h00000001;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp.hold_valid", out_valid, 1);
      check("bp.hold_sum",   sum, 32'h33333333);
      check("bp.hold_ready", in_ready, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp.release_ready", in_ready, 1);
    check("bp.release_valid", out_valid, 0);
    repeat (N + 1) @(posedge clk);
    #1;
    check("bp.no_accept_valid", out_valid, 0);
    check("bp.no_accept_sum",   sum, 32'h33333333);

    // Reset two cycles into a run discards it.
    start(1'b0, 32'h00000064, 32'h000000C8, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_mid.out_valid", out_valid, 0);
    check("rst_mid.in_ready",  in_ready, 1);
    check("rst_mid.sum",       sum, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    got1 = 0;
    for (int i = 0; i < N + 2; i++) begin
      @(posedge clk); #1;
      if (out_valid) got1 = 1;
    end
    check("rst_mid.no_pulse", got1, 0);
    run_vec('{1'b0, 32'd3, 32'd4, 1'b0, 32'd7, 1'b0, 1'b0, 1'b0}, "rst_mid.fresh");

    // Back-to-back with out_ready held high.
    in_valid = 1'b1; mode = 1'b0; a = 32'd1; b = 32'd2; carry_in = 1'b0;
    @(posedge clk); #1;
    mode = 1'b1; a = 32'd10; b = 32'd4;
    e = 0; got1 = 0; acc = 0; held = '0;
    while (!acc && e < 20) begin
      if (out_valid && !got1) begin
        held = sum;
        got1 = 1;
      end
      acc = in_ready;
      @(posedge clk); #1;
      e++;
    end
    in_valid = 1'b0;
    check("b2b.first_seen", got1, 1);
    check("b2b.first_sum",  held, 32'd3);
    check("b2b.spacing",    e, N + 2);
    wait_result(n);
    check("b2b.latency",    n, N);
    check("b2b.second_sum", sum, 32'd6);
    check("b2b.second_co",  carry_out, 1);
    check("b2b.second_ov",  overflow, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
